// File: rtl/rdm_circ_reader.sv
// rdm_circ_reader: reads an E-LLR circular buffer from an arbitrary LLR offset and
// repacks Ncb LLRs into LANES-wide words on a valid/ready stream.
module rdm_circ_reader #(
   parameter int LANES      = 16,
   parameter int LLR_W      = 6,
   parameter int ADDR_W     = 16,
   parameter int LEN_W      = 16,
   parameter int RD_LAT     = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                   i_core_clk,
   input  logic                   i_rx_rstn,
   input  logic                   i_rx_fsm_rstn,
   input  logic                   i_start,
   input  logic [LEN_W-1:0]       i_e_size,
   input  logic [LEN_W-1:0]       i_ncb_size,
   input  logic [LEN_W-1:0]       i_start_offset,
   output logic                   o_busy,
   output logic                   o_rd_en,
   output logic [ADDR_W-1:0]      o_rd_addr,
   input  logic [LANES*LLR_W-1:0] i_rd_data,
   output logic                   o_valid,
   input  logic                   i_ready,
   output logic [LANES*LLR_W-1:0] o_data,
   output logic [LANES-1:0]       o_lane_valid,
   output logic                   o_last,
   output logic                   o_done,
   output logic                   o_cfg_err
);
   localparam int W  = LANES * LLR_W;
   localparam int L1 = LEN_W + 1;
   localparam int SW = $clog2(2 * LANES + 1);
   localparam int FW = $clog2(FIFO_DEPTH);
   localparam int FC = FW + 1;
   localparam logic [L1-1:0] LN = L1'(LANES);

   typedef enum logic [1:0] {IDLE, CHECK, RUN, FINISH} state_t;
   state_t state;
   logic [L1-1:0] e, ncb, off, nw, rem, skip, rd_ptr, pk_ptr, issued, appended;
   logic [W-1:0] fifo [FIFO_DEPTH];
   logic [FW-1:0] wp, rp;
   logic [FC-1:0] fcnt;
   logic [RD_LAT-1:0] tag;
   logic [2*W-1:0] stg;
   logic [SW-1:0] cnt, base;
   logic first;

   logic [L1-1:0] nw_c, s, en, need, avail, nadd;
   logic [W-1:0] head, hs, hm;
   logic [2*W-1:0] ins, nstg;
   logic [LANES-1:0] lv;
   logic ret, hv, issue, pop, push, fpop, xfer, last, rd_wrap, pk_wrap;

   // Staging keeps every lane at or beyond cnt zero, so new LLRs can be OR-ed in.
   always_comb begin
      nw_c = (e + LN - L1'(1)) / LN;
      ret = tag[RD_LAT-1];
      hv = fcnt != '0 || ret;
      head = fcnt != '0 ? fifo[rp] : i_rd_data;
      rd_wrap = rd_ptr == nw - L1'(1);
      pk_wrap = pk_ptr == nw - L1'(1);
      issue = state == RUN && $countones(tag) + int'(fcnt) < FIFO_DEPTH && issued < ncb + skip;
      o_valid = state == RUN && (cnt >= SW'(LANES) || (appended == ncb && cnt != '0));
      last = appended == ncb && cnt <= SW'(LANES);
      o_last = o_valid && last;
      xfer = o_valid && i_ready;
      base = !xfer ? cnt : last ? '0 : cnt - SW'(LANES);
      s = first ? skip : '0;
      en = pk_wrap ? rem : LN;
      avail = en - s;
      need = ncb - appended;
      nadd = avail < need ? avail : need;
      pop = state == RUN && hv && appended < ncb && base <= SW'(LANES);
      push = ret && !(pop && fcnt == '0);
      fpop = pop && fcnt != '0;
      hs = head >> (s * LLR_W);
      hm = '0;
      lv = '0;
      for (int k = 0; k < LANES; k++) begin
         hm[k*LLR_W +: LLR_W] = L1'(k) < nadd ? '1 : '0;
         lv[k] = SW'(k) < cnt;
      end
      ins = {{W{1'b0}}, hs & hm} << (base * LLR_W);
      nstg = (!xfer ? stg : last ? '0 : stg >> W) | (pop ? ins : '0);
      o_data = o_valid ? stg[W-1:0] : '0;
      o_lane_valid = !o_valid ? '0 : last ? lv : '1;
      o_busy = state == CHECK || state == RUN;
      o_rd_en = issue;
      o_rd_addr = issue ? ADDR_W'(rd_ptr) : '0;
   end

   always_ff @(posedge i_core_clk) if (push) fifo[wp] <= i_rd_data;

   always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
      if (!i_rx_rstn) begin
         state <= IDLE;
         {e, ncb, off, nw, rem, skip} <= '0;
         {rd_ptr, pk_ptr, issued, appended} <= '0;
         {wp, rp, fcnt, tag, stg, cnt, first} <= '0;
         o_done <= 1'b0;
         o_cfg_err <= 1'b0;
      end else begin
         o_done <= 1'b0;
         o_cfg_err <= 1'b0;
         tag <= RD_LAT'({tag, issue});
         fcnt <= fcnt + FC'(push) - FC'(fpop);
         if (push) wp <= wp + FW'(1);
         if (fpop) rp <= rp + FW'(1);
         case (state)
            IDLE: if (i_start) begin
               e <= L1'(i_e_size);
               ncb <= L1'(i_ncb_size);
               off <= L1'(i_start_offset);
               state <= CHECK;
            end
            CHECK: if (e == '0 || ncb == '0 || off >= e) begin
               o_cfg_err <= 1'b1;
               state <= IDLE;
            end else begin
               nw <= nw_c;
               rem <= e - (nw_c - L1'(1)) * LN;
               rd_ptr <= off / LN;
               pk_ptr <= off / LN;
               skip <= off % LN;
               {issued, appended, stg, cnt} <= '0;
               first <= 1'b1;
               state <= RUN;
            end
            RUN: begin
               if (issue) begin
                  rd_ptr <= rd_wrap ? '0 : rd_ptr + L1'(1);
                  issued <= issued + (rd_wrap ? rem : LN);
               end
               if (pop) begin
                  pk_ptr <= pk_wrap ? '0 : pk_ptr + L1'(1);
                  first <= 1'b0;
                  appended <= appended + nadd;
               end
               stg <= nstg;
               cnt <= pop ? base + SW'(nadd) : base;
               if (xfer && last) begin
                  o_done <= 1'b1;
                  state <= FINISH;
               end
            end
            FINISH: state <= IDLE;
         endcase
         // Soft abort: dropping the tags discards any read still in flight.
         if (!i_rx_fsm_rstn) begin
            state <= IDLE;
            {wp, rp, fcnt, tag, stg, cnt} <= '0;
            o_done <= 1'b0;
            o_cfg_err <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_rdm_circ_reader.sv
// tb_rdm_circ_reader: directed jobs against a modelled RD_LAT=2 buffer with a
// negedge transfer monitor; expected words are rebuilt from (off+n) mod E.
module tb_rdm_circ_reader;
   localparam int LANES = 16;
   localparam int W = 96;

   logic clk = 1'b0, rstn = 1'b0, fsm_rstn = 1'b1, start = 1'b0, ready = 1'b1;
   logic [15:0] e_size = '0, ncb_size = '0, start_off = '0;
   logic busy, rd_en, valid, last, done, cfg_err;
   logic [15:0] rd_addr, lane_valid;
   logic [W-1:0] rd_data = '0, p1 = '0, data;
   int vectors = 0, miscompares = 0;
   int cur_e = 0, seed = 0, cyc = 0, start_cyc = 0, snap = 0, stall_rd = 0;
   logic pre_valid = 1'b0;

   always #5 clk = ~clk;

   rdm_circ_reader dut (
      .i_core_clk(clk), .i_rx_rstn(rstn), .i_rx_fsm_rstn(fsm_rstn), .i_start(start),
      .i_e_size(e_size), .i_ncb_size(ncb_size), .i_start_offset(start_off), .o_busy(busy),
      .o_rd_en(rd_en), .o_rd_addr(rd_addr), .i_rd_data(rd_data), .o_valid(valid),
      .i_ready(ready), .o_data(data), .o_lane_valid(lane_valid), .o_last(last),
      .o_done(done), .o_cfg_err(cfg_err)
   );

   function automatic logic [5:0] llr(int j);
      return 6'((j * 37 + 11 + seed * 13) ^ (j >> 3));
   endfunction

   function automatic logic [W-1:0] buf_word(int a);
      logic [W-1:0] w;
      w = '0;
      for (int k = 0; k < LANES; k++) w[k*6 +: 6] = (a * 16 + k < cur_e) ? llr(a * 16 + k) : 6'h2A;
      return w;
   endfunction

   always @(posedge clk) begin
      p1 <= rd_en ? buf_word(int'(rd_addr)) : '0;
      rd_data <= p1;
      cyc <= cyc + 1;
   end

   logic [W-1:0] q_data[$];
   logic [15:0] q_mask[$];
   logic q_last[$];
   int q_addr[$];
   int n_rd, n_xfer, n_done, n_err, last_cyc, done_cyc, first_v, stall_bad = 0, max_commit;
   logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
   logic [W-1:0] pd = '0;
   logic [15:0] pm = '0;

   always @(negedge clk) begin
      if (rd_en) begin n_rd++; q_addr.push_back(int'(rd_addr)); end
      if (valid && first_v < 0) first_v = cyc;
      if (valid && ready) begin
         q_data.push_back(data); q_mask.push_back(lane_valid); q_last.push_back(last);
         n_xfer++;
         if (last) last_cyc = cyc;
      end
      if (done) begin n_done++; done_cyc = cyc; end
      if (cfg_err) n_err++;
      if (pv && !pr && !(valid && data === pd && lane_valid === pm && last === pl)) stall_bad++;
      if (n_rd - n_xfer > max_commit) max_commit = n_rd - n_xfer;
      pv = valid; pr = ready; pd = data; pm = lane_valid; pl = last;
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // mode 0: ready high; 1: ready toggles then stalls; 2: stray start mid-job; 3: soft abort mid-job
   task automatic run_job(input int e, input int n, input int o, input int mode, input int sd);
      int k;
      q_data.delete(); q_mask.delete(); q_last.delete(); q_addr.delete();
      n_rd = 0; n_xfer = 0; n_done = 0; n_err = 0; first_v = -1; max_commit = 0;
      last_cyc = -1; done_cyc = -1;
      @(posedge clk); #1;
      seed = sd; cur_e = e;
      e_size = 16'(e); ncb_size = 16'(n); start_off = 16'(o); start = 1'b1; ready = 1'b1;
      start_cyc = cyc;
      k = 0;
      while (k < 600 && n_done == 0 && n_err == 0) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (mode == 1) ready = (k < 20) ? (k % 2 == 0) : (k >= 30);
         if (mode == 1 && k == 26) snap = n_rd;
         if (mode == 1 && k == 30) stall_rd = n_rd - snap;
         if (mode == 2 && k == 3) begin start = 1'b1; e_size = 16'd32; ncb_size = 16'd8; start_off = 16'd3; end
         if (mode == 3 && k == 8) begin pre_valid = valid; fsm_rstn = 1'b0; end
         if (mode == 3 && k == 9) begin fsm_rstn = 1'b1; break; end
         k++;
      end
      if (mode != 3) chk("job_end", 128'(n_done + n_err), 128'(1));
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic check_words(input int e, input int n, input int o);
      int nw;
      logic [W-1:0] ed;
      logic [15:0] em;
      nw = (n + 15) / 16;
      chk("word_count", 128'(q_data.size()), 128'(nw));
      for (int w = 0; w < nw && w < q_data.size(); w++) begin
         ed = '0; em = '0;
         for (int k = 0; k < 16; k++)
            if (w * 16 + k < n) begin ed[k*6 +: 6] = llr((o + w * 16 + k) % e); em[k] = 1'b1; end
         chk("data", 128'(q_data[w]), 128'(ed));
         chk("mask", 128'(q_mask[w]), 128'(em));
         chk("last", 128'(q_last[w]), 128'(w == nw - 1));
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outs", 128'({valid, busy, rd_en, done, cfg_err, last, lane_valid, data}), 128'(0));
      rstn = 1'b1;
      // Aligned single pass
      run_job(64, 64, 0, 0, 1);
      check_words(64, 64, 0);
      chk("t1_rd_cnt", 128'(n_rd), 128'(4));
      for (int i = 0; i < 4 && i < q_addr.size(); i++) chk("t1_addr", 128'(q_addr[i]), 128'(i));
      chk("t1_done_after_last", 128'(done_cyc - last_cyc), 128'(1));
      chk("t1_first_valid_le5", 128'(first_v - start_cyc <= 5), 128'(1));
      // E not a multiple of LANES, wrapping
      run_job(40, 96, 0, 0, 2);
      check_words(40, 96, 0);
      for (int i = 0; i < 4 && i < q_addr.size(); i++) chk("t2_addr", 128'(q_addr[i]), 128'(i % 3));
      // Unaligned offset, short job
      run_job(64, 20, 5, 0, 3);
      check_words(64, 20, 5);
      // Backpressure
      run_job(64, 256, 0, 1, 4);
      check_words(64, 256, 0);
      chk("t4_stall_hold", 128'(stall_bad), 128'(0));
      chk("t4_rd_stopped", 128'(stall_rd), 128'(0));
      chk("t4_commit_le6", 128'(max_commit <= 6), 128'(1));
      // Config error
      run_job(64, 64, 64, 0, 5);
      chk("t5_err", 128'(n_err), 128'(1));
      chk("t5_no_rd", 128'(n_rd), 128'(0));
      chk("t5_no_xfer", 128'(n_xfer), 128'(0));
      chk("t5_idle", 128'(busy), 128'(0));
      // Stray start while busy, wrap at full throughput
      run_job(64, 128, 0, 2, 6);
      check_words(64, 128, 0);
      chk("t5b_no_err", 128'(n_err), 128'(0));
      chk("t5b_thru", 128'(last_cyc - first_v), 128'(7));
      // Soft abort then clean job
      run_job(64, 256, 0, 3, 7);
      chk("t6_was_valid", 128'(pre_valid), 128'(1));
      chk("t6_valid_cleared", 128'(valid), 128'(0));
      chk("t6_busy_cleared", 128'(busy), 128'(0));
      run_job(32, 32, 0, 0, 8);
      check_words(32, 32, 0);
      chk("t6_xfers", 128'(n_xfer), 128'(2));
      chk("stall_hold_all", 128'(stall_bad), 128'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
